// File: rtl/one_to_four_tdm.sv
// 1:4 time-division demultiplexer with frame alignment tracking.
// Steers a marked serial sample stream into four channels and frame snapshots.
module one_to_four_tdm #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               in_valid,
   input  logic               frame_start,
   input  logic [WIDTH-1:0]   in_data,
   output logic [4*WIDTH-1:0] ch,
   output logic [3:0]         ch_stb,
   output logic [4*WIDTH-1:0] frame,
   output logic               frame_valid,
   output logic [1:0]         slot,
   output logic               sync_err
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [1:0]         slot_q, slot_d;
   logic [4*WIDTH-1:0] ch_q, ch_d;
   logic [4*WIDTH-1:0] frame_q, frame_d;
   logic [3:0]         ch_stb_q, ch_stb_d;
   logic               frame_valid_q, frame_valid_d;
   logic               sync_err_q, sync_err_d;
   logic               accept;

   assign accept = en & in_valid;

   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      ch_d          = ch_q;
      frame_d       = frame_q;
      ch_stb_d      = 4'b0000;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      if (accept) begin
         if (state_q == IDLE) begin
            if (frame_start) begin
               ch_d[WIDTH-1:0] = in_data;
               ch_stb_d        = 4'b0001;
               slot_d          = 2'd1;
               state_d         = RUN;
            end
         end else if (frame_start) begin
            // early restart drops the partial frame but keeps alignment
            sync_err_d      = (slot_q != 2'd0);
            ch_d[WIDTH-1:0] = in_data;
            ch_stb_d        = 4'b0001;
            slot_d          = 2'd1;
         end else if (slot_q == 2'd0) begin
            sync_err_d = 1'b1;
            state_d    = IDLE;
         end else begin
            ch_d[slot_q*WIDTH +: WIDTH] = in_data;
            ch_stb_d[slot_q]            = 1'b1;
            slot_d                      = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
               frame_d       = {in_data, ch_q[3*WIDTH-1:0]};
               frame_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         slot_q        <= 2'd0;
         ch_q          <= '0;
         frame_q       <= '0;
         ch_stb_q      <= 4'b0000;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         ch_q          <= ch_d;
         frame_q       <= frame_d;
         ch_stb_q      <= ch_stb_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign ch          = ch_q;
   assign ch_stb      = ch_stb_q;
   assign frame       = frame_q;
   assign frame_valid = frame_valid_q;
   assign slot        = slot_q;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_one_to_four_tdm.sv
// Bench for one_to_four_tdm: directed scenarios plus randomized traffic
// compared against an array-based frame model.
module tb_one_to_four_tdm;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           en = 1'b0;
   logic           in_valid = 1'b0;
   logic           frame_start = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic [4*W-1:0] ch;
   logic [3:0]     ch_stb;
   logic [4*W-1:0] frame;
   logic           frame_valid;
   logic [1:0]     slot;
   logic           sync_err;

   int n_chk = 0;
   int n_bad = 0;

   logic [W-1:0] m_ch[4];
   logic [W-1:0] m_fr[4];
   bit           m_sync;
   int           m_next;
   logic [3:0]   m_stb;
   bit           m_fv;
   bit           m_se;

   one_to_four_tdm #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
      .frame_start(frame_start), .in_data(in_data), .ch(ch),
      .ch_stb(ch_stb), .frame(frame), .frame_valid(frame_valid),
      .slot(slot), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4*W-1:0] pack(input logic [W-1:0] a[4]);
      return {a[3], a[2], a[1], a[0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_ch[i] = '0;
         m_fr[i] = '0;
      end
      m_sync = 0;
      m_next = 0;
      m_stb  = '0;
      m_fv   = 0;
      m_se   = 0;
   endtask

   task automatic model_step(input bit e, input bit v, input bit fs,
                             input logic [W-1:0] d);
      m_stb = '0;
      m_fv  = 0;
      m_se  = 0;
      if (!(e && v)) return;
      if (!m_sync) begin
         if (fs) begin
            m_ch[0] = d;
            m_stb   = 4'b0001;
            m_next  = 1;
            m_sync  = 1;
         end
      end else if (fs) begin
         m_se    = (m_next != 0);
         m_ch[0] = d;
         m_stb   = 4'b0001;
         m_next  = 1;
      end else if (m_next == 0) begin
         m_se   = 1;
         m_sync = 0;
      end else begin
         m_ch[m_next] = d;
         m_stb        = 4'(1 << m_next);
         if (m_next == 3) begin
            m_fr   = m_ch;
            m_fv   = 1;
            m_next = 0;
         end else begin
            m_next++;
         end
      end
   endtask

   task automatic check_all(input string p);
      check({p, "_ch"}, ch, pack(m_ch));
      check({p, "_stb"}, ch_stb, m_stb);
      check({p, "_frame"}, frame, pack(m_fr));
      check({p, "_fv"}, frame_valid, m_fv);
      check({p, "_slot"}, slot, m_next[1:0]);
      check({p, "_serr"}, sync_err, m_se);
      check({p, "_excl"}, frame_valid & sync_err, 0);
      check({p, "_onehot"}, ($countones(ch_stb) <= 1), 1);
   endtask

   task automatic cyc(input bit e, input bit v, input bit fs,
                      input logic [W-1:0] d, input string p);
      en          = e;
      in_valid    = v;
      frame_start = fs;
      in_data     = d;
      @(posedge clk);
      model_step(e, v, fs, d);
      #1;
      check_all(p);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit e, v, fs;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      cyc(1, 1, 1, 8'hA0, "tp1");
      cyc(1, 1, 0, 8'hB1, "tp1");
      cyc(1, 1, 0, 8'hC2, "tp1");
      cyc(1, 1, 0, 8'hD3, "tp1");
      check("tp1_frame", frame, 32'hD3C2B1A0);
      check("tp1_fv", frame_valid, 1);
      check("tp1_slot", slot, 2'd0);

      do_reset();
      cyc(1, 1, 0, 8'h11, "tp2");
      cyc(1, 1, 0, 8'h22, "tp2");
      check("tp2_noerr", sync_err, 0);
      cyc(1, 1, 1, 8'h33, "tp2");
      check("tp2_ch0", ch[7:0], 8'h33);
      check("tp2_slot", slot, 2'd1);
      cyc(1, 1, 0, 8'h44, "tp2");
      cyc(1, 1, 0, 8'h55, "tp2");
      cyc(1, 1, 0, 8'h66, "tp2");
      check("tp2_frame", frame, 32'h66554433);

      cyc(1, 1, 1, 8'h10, "tp3");
      cyc(1, 1, 0, 8'h20, "tp3");
      cyc(1, 1, 1, 8'h30, "tp3");
      check("tp3_serr", sync_err, 1);
      check("tp3_fv", frame_valid, 0);
      check("tp3_frame", frame, 32'h66554433);
      check("tp3_ch0", ch[7:0], 8'h30);
      check("tp3_slot", slot, 2'd1);

      cyc(1, 1, 0, 8'h40, "tp4");
      cyc(1, 1, 0, 8'h50, "tp4");
      cyc(1, 1, 0, 8'h60, "tp4");
      check("tp4_frame", frame, 32'h60504030);
      cyc(1, 1, 0, 8'h55, "tp4");
      check("tp4_serr", sync_err, 1);
      check("tp4_stb", ch_stb, 4'b0000);
      cyc(1, 1, 0, 8'h77, "tp4");
      check("tp4_noerr", sync_err, 0);

      cyc(1, 1, 1, 8'hA0, "tp5");
      cyc(1, 1, 0, 8'hB1, "tp5");
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, i == 1, 8'hEE, "tp5_stall");
         check("tp5_frozen_stb", ch_stb, 4'b0000);
      end
      cyc(1, 0, 0, 8'hEF, "tp5_bubble");
      cyc(1, 1, 0, 8'hC2, "tp5");
      cyc(1, 1, 0, 8'hD3, "tp5");
      check("tp5_frame", frame, 32'hD3C2B1A0);

      cyc(1, 1, 1, 8'h01, "tp6");
      cyc(1, 1, 0, 8'h02, "tp6");
      cyc(1, 1, 0, 8'h03, "tp6");
      #2;
      rst_n = 1'b0;
      #1;
      check("tp6_ch", ch, 0);
      check("tp6_frame", frame, 0);
      check("tp6_slot", slot, 0);
      check("tp6_stb", ch_stb, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1, 1, 1, 8'hAA, "tp6");
      cyc(1, 1, 0, 8'hBB, "tp6");
      cyc(1, 1, 0, 8'hCC, "tp6");
      cyc(1, 1, 0, 8'hDD, "tp6");
      check("tp6_frame2", frame, 32'hDDCCBBAA);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(499) == 0) begin
            do_reset();
         end
         e  = ($urandom_range(9) != 0);
         v  = ($urandom_range(4) != 0);
         if (m_next == 0) fs = ($urandom_range(9) != 0);
         else             fs = ($urandom_range(11) == 0);
         cyc(e, v, fs, 8'($urandom), "rnd");
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/one_to_four_tdm.md
Name: one_to_four_tdm

Overview:
- 1:4 time-division demultiplexer: the receive end of the 4:1 slot-selected mux path.
- Accepts a serial stream of samples tagged with a frame-start marker, steers slots 0..3 into four registered output channels, and publishes an atomic 4-sample frame snapshot.
- Tracks frame alignment and flags sync errors.

Parameters:
WIDTH, 8, bits per sample/channel.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  block enable; 0 freezes all state and ignores inputs.
in_valid  input  1  in_data carries a sample this cycle.
frame_start  input  1  qualifies the current sample as slot 0; meaningful only with in_valid.
in_data  input  WIDTH  sample payload.
ch  output  4*WIDTH  live channel registers; slot k in ch[k*WIDTH +: WIDTH].
ch_stb  output  4  one-hot, one-cycle strobe; bit k=1 means ch slot k was updated this cycle.
frame  output  4*WIDTH  snapshot of the last complete frame, same slot packing as ch.
frame_valid  output  1  one-cycle pulse; frame updated this cycle.
slot  output  2  next expected slot index.
sync_err  output  1  one-cycle pulse on alignment violation.

Behaviour:
- Reset (async assert, sync release): ch=0, frame=0, ch_stb=0, frame_valid=0, slot=0, sync_err=0, state=IDLE.
- All outputs registered. A sample accepted at edge N is visible on ch/ch_stb after edge N, so latency is 1 cycle.
- "Accept" means a rising edge with en=1 and in_valid=1.
- en=0: all registers hold. ch_stb, frame_valid and sync_err are forced to 0 for that cycle.
- Pulse outputs (ch_stb, frame_valid, sync_err) are 0 on any cycle with no accept.
- State IDLE (unaligned):
  - Accept with frame_start=1: write ch slot 0, ch_stb=0001, slot<=1, go RUN.
  - Accept with frame_start=0: sample dropped, no strobe, no error, stay IDLE.
- State RUN (aligned, slot=k):
  - frame_start=0, k!=0: write ch slot k, ch_stb bit k, slot<=k+1 (mod 4).
  - When k=3: additionally frame <= {in_data, ch slots 2..0}, frame_valid=1, slot<=0.
  - The frame snapshot includes the slot-3 sample written this same cycle.
  - frame_start=1, k=0: normal slot 0 write, slot<=1.
  - frame_start=1, k!=0 (early restart): sync_err=1.
    - Partial frame discarded; frame not updated and no frame_valid.
    - Sample written as slot 0, ch_stb=0001, slot<=1, stay RUN.
    - ch slots 1..3 retain stale values.
  - frame_start=0, k=0 (missing marker): sync_err=1, sample dropped, no strobe, slot stays 0, go IDLE.
- Exactly one of: frame completes, or the partial frame is aborted. frame_valid and sync_err are never both 1 in the same cycle.
- ch_stb is one-hot or zero, never multi-bit.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost and no pulse is emitted.
- ch and frame hold their values indefinitely between updates.

Test Plan:
- Reset then aligned frame, WIDTH=8: accepts A0(fs=1),B1,C2,D3 on consecutive cycles -> ch_stb 0001,0010,0100,1000. frame_valid pulses once, frame=0xD3C2B1A0, slot back to 0, sync_err never set.
- IDLE drop: accepts 0x11,0x22 with fs=0, then 0x33 with fs=1 -> first two ignored with no error. ch slot0=0x33, slot=1.
- Early restart: fs=1 0x10, 0x20, then fs=1 0x30 -> sync_err pulse on the third accept. ch slot0=0x30, slot=1, no frame_valid, frame unchanged.
- Missing marker: a full frame, then next sample 0x55 with fs=0 -> sync_err pulse, sample dropped, state IDLE. A following fs=0 sample produces no error.
- Enable/gaps: frame with en=0 for 3 cycles and in_valid=0 bubbles between slots 1 and 2 -> same frame value as the contiguous case. No strobes during stall cycles, outputs frozen.
- Async reset: assert rst_n=0 mid-cycle after slot 2 -> all outputs 0 immediately without a clock edge. The next frame after release completes normally.
